tsmac_rx_fifo_drain_ctrl: RTL and testbench



---
 rtl/tsmac_rx_fifo_drain_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tsmac_rx_fifo_drain_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsmac_rx_fifo_drain_ctrl.sv
// Read-side frame controller for the TSMAC RX prefetch FIFO: pops 10-bit words
// and delineates frames onto a valid/ready byte stream with length/error status.
module tsmac_rx_fifo_drain_ctrl #(
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned LEN_W      = 11,
    parameter int unsigned IFG_CYCLES = 2
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             enable,
    input  logic             fifo_rd_vld,
    input  logic [9:0]       fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_sof,
    output logic             m_eof,
    output logic             m_err,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_err,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned      GAP_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [LEN_W-1:0] LAST_IDX  = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        XFER,
        DROP,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    state_t           gap_exit;
    state_t           after_frame;
    logic [LEN_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             w_sof;
    logic             w_eof;
    logic             synth;
    logic             trunc;
    logic             drop_inc;

    assign w_sof = fifo_rd_data[8];
    assign w_eof = fifo_rd_data[9];

    always_comb begin
        state_nxt   = state;
        fifo_rd_en  = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_sof       = 1'b0;
        m_eof       = 1'b0;
        m_err       = 1'b0;
        synth       = 1'b0;
        trunc       = 1'b0;
        gap_exit    = enable ? HUNT : IDLE;
        // With no gap configured, a frame end resolves HUNT/IDLE immediately.
        after_frame = (IFG_CYCLES == 0) ? gap_exit : GAP;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = HUNT;
                end
            end
            HUNT: begin
                if (fifo_rd_vld) begin
                    if (w_sof) begin
                        state_nxt = XFER;
                    end else begin
                        fifo_rd_en = 1'b1;
                    end
                end else if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (fifo_rd_vld) begin
                    m_valid = 1'b1;
                    if (w_sof && byte_cnt != '0) begin
                        // Missing EOF: close the frame with a synthetic error beat;
                        // the SOF word stays at the FIFO head for the next frame.
                        synth = 1'b1;
                        m_eof = 1'b1;
                        m_err = 1'b1;
                        if (m_ready) begin
                            state_nxt = after_frame;
                        end
                    end else begin
                        trunc      = (byte_cnt == LAST_IDX) && !w_eof;
                        m_data     = fifo_rd_data[7:0];
                        m_sof      = (byte_cnt == '0);
                        m_eof      = w_eof | trunc;
                        m_err      = trunc;
                        fifo_rd_en = m_ready;
                        if (m_ready) begin
                            if (w_eof) begin
                                state_nxt = after_frame;
                            end else if (trunc) begin
                                state_nxt = DROP;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (fifo_rd_vld) begin
                    if (w_sof) begin
                        state_nxt = after_frame;
                    end else begin
                        fifo_rd_en = 1'b1;
                        if (w_eof) begin
                            state_nxt = after_frame;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = gap_exit;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drop_inc = ((state == HUNT) && fifo_rd_en) ||
                      ((state == XFER) && m_valid && m_ready && (synth || trunc));

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_err  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            gap_cnt    <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

            if (state == XFER && m_valid && m_ready) begin
                if (synth) begin
                    frame_done <= 1'b1;
                    frame_len  <= byte_cnt;
                    frame_err  <= 1'b1;
                    byte_cnt   <= '0;
                end else if (w_eof) begin
                    frame_done <= 1'b1;
                    frame_len  <= byte_cnt + LEN_W'(1);
                    frame_err  <= 1'b0;
                    byte_cnt   <= '0;
                end else if (trunc) begin
                    frame_done <= 1'b1;
                    frame_len  <= MAX_LEN_V;
                    frame_err  <= 1'b1;
                    byte_cnt   <= '0;
                end else begin
                    byte_cnt <= byte_cnt + LEN_W'(1);
                end
            end

            if (drop_inc && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tsmac_rx_fifo_drain_ctrl.sv
// Directed bench for tsmac_rx_fifo_drain_ctrl: one default instance and one with
// MAX_LEN=16, each fed by a simple array-backed prefetch FIFO model.
module tb_tsmac_rx_fifo_drain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic enable = 1'b0;
    logic sel    = 1'b0;
    int   rdy_mode = 0;
    int   cyc = 0;
    logic m_ready;

    always @(posedge clk) cyc <= cyc + 1;
    assign m_ready = (rdy_mode == 0) || cyc[0];

    // FIFO models
    logic [9:0] mem0 [0:511];
    logic [9:0] mem1 [0:511];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic vld0, vld1;
    logic [9:0] fdat0, fdat1;
    assign vld0  = (wp0 != rp0);
    assign vld1  = (wp1 != rp1);
    assign fdat0 = mem0[rp0];
    assign fdat1 = mem1[rp1];

    logic en0, mv0, sof0, eof0, err0, fd0, ferr0;
    logic en1, mv1, sof1, eof1, err1, fd1, ferr1;
    logic [7:0]  md0, md1;
    logic [10:0] flen0, flen1;
    logic [15:0] dc0, dc1;

    tsmac_rx_fifo_drain_ctrl dut0 (
        .rd_clk(clk), .rd_rst(rst), .enable(enable),
        .fifo_rd_vld(vld0), .fifo_rd_data(fdat0), .fifo_rd_en(en0),
        .m_valid(mv0), .m_ready(m_ready), .m_data(md0),
        .m_sof(sof0), .m_eof(eof0), .m_err(err0),
        .frame_done(fd0), .frame_len(flen0), .frame_err(ferr0), .drop_cnt(dc0)
    );

    tsmac_rx_fifo_drain_ctrl #(.MAX_LEN(16), .LEN_W(11), .IFG_CYCLES(2)) dut1 (
        .rd_clk(clk), .rd_rst(rst), .enable(enable),
        .fifo_rd_vld(vld1), .fifo_rd_data(fdat1), .fifo_rd_en(en1),
        .m_valid(mv1), .m_ready(m_ready), .m_data(md1),
        .m_sof(sof1), .m_eof(eof1), .m_err(err1),
        .frame_done(fd1), .frame_len(flen1), .frame_err(ferr1), .drop_cnt(dc1)
    );

    always @(posedge clk) begin
        if (rst) rp0 <= wp0;
        else if (en0) rp0 <= rp0 + 1;
        if (rst) rp1 <= wp1;
        else if (en1) rp1 <= rp1 + 1;
    end

    logic        mv, sof, eof, err, fd, ferr;
    logic [7:0]  md;
    logic [10:0] flen;
    assign mv   = sel ? mv1 : mv0;
    assign sof  = sel ? sof1 : sof0;
    assign eof  = sel ? eof1 : eof0;
    assign err  = sel ? err1 : err0;
    assign md   = sel ? md1 : md0;
    assign fd   = sel ? fd1 : fd0;
    assign ferr = sel ? ferr1 : ferr0;
    assign flen = sel ? flen1 : flen0;

    // Beat / frame-status recorders and stall-stability monitor
    logic [7:0]  b_data [0:1023];
    logic [2:0]  b_flg  [0:1023];
    int          b_cyc  [0:1023];
    logic [10:0] f_len  [0:63];
    logic        f_err  [0:63];
    int          f_cyc  [0:63];
    int nb = 0, nf = 0, stall_viol = 0, bad_pop = 0;
    logic       p_valid = 1'b0, p_ready = 1'b0;
    logic [7:0] p_data = '0;
    logic [2:0] p_flg = '0;

    always @(negedge clk) begin
        if (mv && m_ready) begin
            b_data[nb] <= md;
            b_flg[nb]  <= {err, eof, sof};
            b_cyc[nb]  <= cyc;
            nb         <= nb + 1;
        end
        if (fd) begin
            f_len[nf] <= flen;
            f_err[nf] <= ferr;
            f_cyc[nf] <= cyc;
            nf        <= nf + 1;
        end
        if (p_valid && !p_ready && !rst &&
            !(mv && md == p_data && {err, eof, sof} == p_flg))
            stall_viol <= stall_viol + 1;
        p_valid <= mv && !rst;
        p_ready <= m_ready;
        p_data  <= md;
        p_flg   <= {err, eof, sof};
        if ((en0 && !vld0) || (en1 && !vld1)) bad_pop <= bad_pop + 1;
    end

    int tests = 0, fails = 0;

    task automatic push(input logic s, input logic e, input logic [7:0] d);
        if (!sel) begin mem0[wp0] = {e, s, d}; wp0 = wp0 + 1; end
        else      begin mem1[wp1] = {e, s, d}; wp1 = wp1 + 1; end
    endtask

    task automatic push_frame(input int unsigned n, input logic [7:0] base, input logic with_eof);
        for (int unsigned i = 0; i < n; i++)
            push(i == 0, with_eof && (i == n - 1), base + 8'(i));
    endtask

    task automatic wait_frames(input int target, input int budget, output logic ok);
        int k = 0;
        while (nf < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        ok = (nf >= target);
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({mv0, en0, sof0, eof0, err0, md0, fd0, ferr0} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl0: got %b, expected all 0", {mv0, en0, sof0, eof0, err0, md0, fd0, ferr0});
        end
        tests++;
        if (flen0 !== 11'd0 || dc0 !== 16'd0) begin
            fails++;
            $display("FAIL reset_status0: got len=%0d drop=%0d, expected 0/0", flen0, dc0);
        end
        tests++;
        if ({mv1, en1, fd1, ferr1, flen1, dc1} !== '0) begin
            fails++;
            $display("FAIL reset_dut16: got %h, expected 0", {mv1, en1, fd1, ferr1, flen1, dc1});
        end
        rst = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame;
        int sb = nb, sf = nf, bad = 0;
        logic ok;
        push_frame(64, 8'h01, 1'b1);
        push_frame(4, 8'hB0, 1'b1);
        wait_frames(sf + 2, 400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_timeout: got %0d frames, expected %0d", nf - sf, 2); end
        tests++;
        if (nb - sb != 68) begin fails++; $display("FAIL basic_beats: got %0d, expected 68", nb - sb); end
        for (int unsigned i = 0; i < 64; i++)
            if (b_data[sb + i] !== 8'h01 + 8'(i) || b_flg[sb + i] !== {1'b0, i == 63, i == 0}) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL basic_data: got %0d bad beats, expected 0", bad); end
        tests++;
        if (f_len[sf] !== 11'd64 || f_err[sf] !== 1'b0) begin
            fails++; $display("FAIL basic_len: got len=%0d err=%b, expected 64/0", f_len[sf], f_err[sf]);
        end
        tests++;
        if (f_cyc[sf] != b_cyc[sb + 63] + 1) begin
            fails++; $display("FAIL basic_done_time: got cycle %0d, expected %0d", f_cyc[sf], b_cyc[sb + 63] + 1);
        end
        // EOF beat, two gap cycles, one HUNT cycle, then the next SOF beat
        tests++;
        if (b_cyc[sb + 64] - b_cyc[sb + 63] != 4) begin
            fails++; $display("FAIL basic_ifg: got spacing %0d, expected 4", b_cyc[sb + 64] - b_cyc[sb + 63]);
        end
        tests++;
        if (f_len[sf + 1] !== 11'd4 || b_flg[sb + 64] !== 3'b001) begin
            fails++; $display("FAIL basic_next: got len=%0d flg=%b, expected 4/001", f_len[sf + 1], b_flg[sb + 64]);
        end
    endtask

    task automatic test_backpressure;
        int sb = nb, sf = nf, bad = 0, sv = stall_viol;
        logic ok;
        rdy_mode = 1;
        push_frame(64, 8'h90, 1'b1);
        wait_frames(sf + 1, 600, ok);
        rdy_mode = 0;
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_timeout: got %0d frames, expected 1", nf - sf); end
        tests++;
        if (nb - sb != 64) begin fails++; $display("FAIL bp_beats: got %0d, expected 64", nb - sb); end
        for (int unsigned i = 0; i < 64; i++)
            if (b_data[sb + i] !== 8'h90 + 8'(i) || b_flg[sb + i] !== {1'b0, i == 63, i == 0}) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL bp_data: got %0d bad beats, expected 0", bad); end
        tests++;
        if (stall_viol != sv) begin fails++; $display("FAIL bp_stable: got %0d violations, expected 0", stall_viol - sv); end
        tests++;
        if (b_cyc[sb + 63] - b_cyc[sb] != 126) begin
            fails++; $display("FAIL bp_span: got %0d cycles, expected 126", b_cyc[sb + 63] - b_cyc[sb]);
        end
        tests++;
        if (f_len[sf] !== 11'd64 || f_err[sf] !== 1'b0) begin
            fails++; $display("FAIL bp_len: got len=%0d err=%b, expected 64/0", f_len[sf], f_err[sf]);
        end
    endtask

    task automatic test_orphan;
        int sb = nb, sf = nf;
        logic ok;
        push(1'b0, 1'b0, 8'h11);
        push(1'b0, 1'b0, 8'h22);
        push(1'b0, 1'b0, 8'h33);
        push(1'b1, 1'b1, 8'h5A);
        wait_frames(sf + 1, 100, ok);
        tests++;
        if (!ok || nb - sb != 1) begin fails++; $display("FAIL orphan_beats: got %0d beats, expected 1", nb - sb); end
        tests++;
        if (b_data[sb] !== 8'h5A || b_flg[sb] !== 3'b011) begin
            fails++; $display("FAIL orphan_beat: got %h/%b, expected 5a/011", b_data[sb], b_flg[sb]);
        end
        tests++;
        if (f_len[sf] !== 11'd1 || f_err[sf] !== 1'b0) begin
            fails++; $display("FAIL orphan_len: got len=%0d err=%b, expected 1/0", f_len[sf], f_err[sf]);
        end
        tests++;
        if (dc0 !== 16'd3) begin fails++; $display("FAIL orphan_drop: got %0d, expected 3", dc0); end
    endtask

    task automatic test_missing_eof;
        int sb = nb, sf = nf, bad = 0;
        logic ok;
        push_frame(10, 8'h40, 1'b0);
        push_frame(5, 8'h60, 1'b1);
        wait_frames(sf + 2, 200, ok);
        tests++;
        if (!ok || nb - sb != 16) begin fails++; $display("FAIL noeof_beats: got %0d, expected 16", nb - sb); end
        for (int unsigned i = 0; i < 10; i++)
            if (b_data[sb + i] !== 8'h40 + 8'(i) || b_flg[sb + i] !== {2'b00, i == 0}) bad++;
        for (int unsigned i = 0; i < 5; i++)
            if (b_data[sb + 11 + i] !== 8'h60 + 8'(i) || b_flg[sb + 11 + i] !== {1'b0, i == 4, i == 0}) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL noeof_data: got %0d bad beats, expected 0", bad); end
        tests++;
        if (b_data[sb + 10] !== 8'h00 || b_flg[sb + 10] !== 3'b110) begin
            fails++; $display("FAIL noeof_synth: got %h/%b, expected 00/110", b_data[sb + 10], b_flg[sb + 10]);
        end
        tests++;
        if (f_len[sf] !== 11'd10 || f_err[sf] !== 1'b1 || f_len[sf + 1] !== 11'd5 || f_err[sf + 1] !== 1'b0) begin
            fails++; $display("FAIL noeof_len: got %0d/%b %0d/%b, expected 10/1 5/0",
                              f_len[sf], f_err[sf], f_len[sf + 1], f_err[sf + 1]);
        end
        tests++;
        if (dc0 !== 16'd4) begin fails++; $display("FAIL noeof_drop: got %0d, expected 4", dc0); end
    endtask

    task automatic test_enable_gate;
        int sb, sf, rpb;
        logic ok;
        enable = 1'b0;
        repeat (6) @(negedge clk);
        sb = nb; sf = nf; rpb = rp0;
        push_frame(3, 8'h70, 1'b1);
        repeat (8) @(negedge clk);
        tests++;
        if (nb != sb || rp0 != rpb) begin
            fails++; $display("FAIL enable_hold: got %0d beats %0d pops, expected 0/0", nb - sb, rp0 - rpb);
        end
        enable = 1'b1;
        wait_frames(sf + 1, 100, ok);
        tests++;
        if (!ok || nb - sb != 3 || f_len[sf] !== 11'd3) begin
            fails++; $display("FAIL enable_resume: got %0d beats len=%0d, expected 3/3", nb - sb, f_len[sf]);
        end
    endtask

    task automatic test_max_len;
        int sb, sf, bad = 0;
        logic ok;
        sel = 1'b1;
        @(negedge clk);
        sb = nb; sf = nf;
        push_frame(20, 8'h80, 1'b1);
        push_frame(3, 8'hC0, 1'b1);
        push_frame(16, 8'hD0, 1'b1);
        wait_frames(sf + 3, 300, ok);
        tests++;
        if (!ok || nb - sb != 35) begin fails++; $display("FAIL maxlen_beats: got %0d, expected 35", nb - sb); end
        for (int unsigned i = 0; i < 15; i++)
            if (b_data[sb + i] !== 8'h80 + 8'(i) || b_flg[sb + i] !== {2'b00, i == 0}) bad++;
        for (int unsigned i = 0; i < 3; i++)
            if (b_data[sb + 16 + i] !== 8'hC0 + 8'(i) || b_flg[sb + 16 + i] !== {1'b0, i == 2, i == 0}) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL maxlen_data: got %0d bad beats, expected 0", bad); end
        tests++;
        if (b_data[sb + 15] !== 8'h8F || b_flg[sb + 15] !== 3'b110) begin
            fails++; $display("FAIL maxlen_trunc: got %h/%b, expected 8f/110", b_data[sb + 15], b_flg[sb + 15]);
        end
        tests++;
        if (b_data[sb + 34] !== 8'hDF || b_flg[sb + 34] !== 3'b010) begin
            fails++; $display("FAIL maxlen_exact: got %h/%b, expected df/010", b_data[sb + 34], b_flg[sb + 34]);
        end
        tests++;
        if (f_len[sf] !== 11'd16 || f_err[sf] !== 1'b1 || f_len[sf + 1] !== 11'd3 || f_err[sf + 1] !== 1'b0 ||
            f_len[sf + 2] !== 11'd16 || f_err[sf + 2] !== 1'b0) begin
            fails++; $display("FAIL maxlen_len: got %0d/%b %0d/%b %0d/%b, expected 16/1 3/0 16/0",
                              f_len[sf], f_err[sf], f_len[sf + 1], f_err[sf + 1], f_len[sf + 2], f_err[sf + 2]);
        end
        tests++;
        if (dc1 !== 16'd1) begin fails++; $display("FAIL maxlen_drop: got %0d, expected 1", dc1); end
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        int k = 0, sf = nf, sb;
        logic ok;
        push_frame(10, 8'h20, 1'b1);
        while (!(mv0 && md0 == 8'h25) && k < 100) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 100) begin fails++; $display("FAIL rstmid_reach: got no beat 5, expected it within 100 cycles"); end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({mv0, en0, sof0, eof0, err0, md0, fd0, ferr0, flen0, dc0} !== '0) begin
            fails++; $display("FAIL rstmid_zero: got %h, expected 0",
                              {mv0, en0, sof0, eof0, err0, md0, fd0, ferr0, flen0, dc0});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (nf != sf) begin fails++; $display("FAIL rstmid_nodone: got %0d frame_done, expected 0", nf - sf); end
        sb = nb;
        push_frame(5, 8'h30, 1'b1);
        wait_frames(sf + 1, 100, ok);
        tests++;
        if (!ok || nb - sb != 5 || b_data[sb] !== 8'h30 || b_flg[sb] !== 3'b001 || f_len[sf] !== 11'd5 || f_err[sf] !== 1'b0) begin
            fails++; $display("FAIL rstmid_next: got beats=%0d first=%h/%b len=%0d err=%b, expected 5 30/001 5/0",
                              nb - sb, b_data[sb], b_flg[sb], f_len[sf], f_err[sf]);
        end
        tests++;
        if (dc0 !== 16'd0) begin fails++; $display("FAIL rstmid_drop: got %0d, expected 0", dc0); end
    endtask

    task automatic test_fifo_protocol;
        tests++;
        if (bad_pop != 0) begin fails++; $display("FAIL pop_empty: got %0d illegal pops, expected 0", bad_pop); end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_backpressure;
        test_orphan;
        test_missing_eof;
        test_enable_gate;
        test_max_len;
        test_reset_midframe;
        test_fifo_protocol;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
